// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 receive path: the receiver FSM state
// encoding, the number of data bits per frame and the odd-parity rule.
// No ports (package).
// ---------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam int PS2_DATA_BITS = 8;

  // PS/2 uses odd parity: data bits XOR parity bit must equal this value.
  localparam logic PS2_ODD_PARITY = 1'b1;

  function automatic logic ps2_parity_ok(input logic data_xor, input logic parity_bit);
    return (data_xor ^ parity_bit) == PS2_ODD_PARITY;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO. The head entry is held in a register so
// the consumer sees it without a read request; the storage array has no
// reset so it can map onto RAM.
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   push, push_data write request and data
//   pop             head consumed (ignored while empty)
//   head_data       entry at the head (0 after reset)
//   valid           FIFO non-empty
//   count           occupancy, 0..DEPTH
//   overflow        1-cycle pulse: push dropped because FIFO full and no pop
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] head_reg;
  logic             overflow_reg;

  logic             empty;
  logic             full;
  logic             pop_ok;
  logic             push_ok;
  logic [AW-1:0]    rd_ptr_next;

  assign empty       = (count_reg == '0);
  assign full        = (count_reg == CW'(DEPTH));
  assign pop_ok      = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok     = push & (~full | pop_ok);
  assign rd_ptr_next = rd_ptr_reg + AW'(1);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      head_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      overflow_reg <= push & ~push_ok;
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_next;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      // The incoming byte becomes the head when the FIFO is (or is about to
      // become) empty; otherwise a pop loads the next stored entry.
      if (push_ok && (empty || (pop_ok && count_reg == CW'(1)))) begin
        head_reg <= push_data;
      end else if (pop_ok) begin
        head_reg <= mem[rd_ptr_next];
      end
    end
  end

  assign head_data = head_reg;
  assign valid     = ~empty;
  assign count     = count_reg;
  assign overflow  = overflow_reg;

endmodule

// File: rtl/ps2_rx_fifo.sv
// ---------------------------------------------------------------------------
// ps2_rx_fifo
// PS/2 device-to-host receiver: synchronises the PS/2 pins, deglitches the
// PS/2 clock, deframes 11-bit frames (start, 8 data LSB first, odd parity,
// stop), guards each frame with a watchdog, and queues good bytes in a FIFO
// drained through a valid/ready stream.
// Ports:
//   clk, reset        system clock, synchronous active-low reset
//   ps2clk, ps2data   raw PS/2 pins
//   m_data, m_valid   FIFO head byte / FIFO non-empty
//   m_ready           consumer accepts head on m_valid & m_ready
//   fifo_count        FIFO occupancy
//   parity_err        pulse: bad parity, frame discarded
//   frame_err         pulse: stop bit 0, frame discarded
//   timeout_err       pulse: stalled frame aborted
//   overflow          pulse: good byte dropped, FIFO full
// ---------------------------------------------------------------------------
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 16,
  parameter int CHECK_PARITY   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps2clk,
  input  logic                          ps2data,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          timeout_err,
  output logic                          overflow
);

  localparam int FLW = $clog2(FILTER_LEN + 1);
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BCW = $clog2(PS2_DATA_BITS);

  // -------------------------------------------------------------------------
  // Two-flop synchronisers; bit 0 = ps2clk, bit 1 = ps2data. Idle level is 1.
  // -------------------------------------------------------------------------
  logic [1:0] raw_pins;
  logic [1:0] sync_meta_reg;
  logic [1:0] sync_reg;

  assign raw_pins = {ps2data, ps2clk};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      always_ff @(posedge clk) begin
        if (!reset) begin
          sync_meta_reg[gi] <= 1'b1;
          sync_reg[gi]      <= 1'b1;
        end else begin
          sync_meta_reg[gi] <= raw_pins[gi];
          sync_reg[gi]      <= sync_meta_reg[gi];
        end
      end
    end
  endgenerate

  logic ps2clk_sync;
  logic ps2data_sync;

  assign ps2clk_sync  = sync_reg[0];
  assign ps2data_sync = sync_reg[1];

  // -------------------------------------------------------------------------
  // Clock filter: follow the synchronised clock only once it has disagreed
  // with the filtered level for FILTER_LEN consecutive cycles.
  // -------------------------------------------------------------------------
  logic           filt_reg;
  logic           filt_d_reg;
  logic [FLW-1:0] filt_cnt_reg;
  logic           fall;

  always_ff @(posedge clk) begin
    if (!reset) begin
      filt_reg     <= 1'b1;
      filt_d_reg   <= 1'b1;
      filt_cnt_reg <= '0;
    end else begin
      filt_d_reg <= filt_reg;
      if (ps2clk_sync != filt_reg) begin
        if (filt_cnt_reg == FLW'(FILTER_LEN - 1)) begin
          filt_reg     <= ps2clk_sync;
          filt_cnt_reg <= '0;
        end else begin
          filt_cnt_reg <= filt_cnt_reg + FLW'(1);
        end
      end else begin
        filt_cnt_reg <= '0;
      end
    end
  end

  assign fall = filt_d_reg & ~filt_reg;

  // -------------------------------------------------------------------------
  // Frame FSM with watchdog. All outputs registered.
  // -------------------------------------------------------------------------
  ps2_state_e               state_reg;
  logic [BCW-1:0]           bit_cnt_reg;
  logic [PS2_DATA_BITS-1:0] shift_reg;
  logic                     par_acc_reg;
  logic                     par_ok_reg;
  logic [WDW-1:0]           wd_reg;
  logic                     push_reg;
  logic [PS2_DATA_BITS-1:0] push_data_reg;
  logic                     parity_err_reg;
  logic                     frame_err_reg;
  logic                     timeout_err_reg;
  logic                     timeout_hit;

  // A fall on the expiry cycle keeps the frame alive.
  assign timeout_hit = (state_reg != ST_IDLE) && !fall &&
                       (wd_reg == WDW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= ST_IDLE;
      bit_cnt_reg     <= '0;
      shift_reg       <= '0;
      par_acc_reg     <= 1'b0;
      par_ok_reg      <= 1'b0;
      wd_reg          <= '0;
      push_reg        <= 1'b0;
      push_data_reg   <= '0;
      parity_err_reg  <= 1'b0;
      frame_err_reg   <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      push_reg        <= 1'b0;
      parity_err_reg  <= 1'b0;
      frame_err_reg   <= 1'b0;
      timeout_err_reg <= 1'b0;

      if (state_reg == ST_IDLE || fall) begin
        wd_reg <= '0;
      end else begin
        wd_reg <= wd_reg + WDW'(1);
      end

      if (timeout_hit) begin
        timeout_err_reg <= 1'b1;
        state_reg       <= ST_IDLE;
      end else if (fall) begin
        case (state_reg)
          ST_IDLE: begin
            if (!ps2data_sync) begin
              bit_cnt_reg <= '0;
              par_acc_reg <= 1'b0;
              state_reg   <= ST_DATA;
            end
          end
          ST_DATA: begin
            shift_reg   <= {ps2data_sync, shift_reg[PS2_DATA_BITS-1:1]};
            par_acc_reg <= par_acc_reg ^ ps2data_sync;
            bit_cnt_reg <= bit_cnt_reg + BCW'(1);
            if (bit_cnt_reg == BCW'(PS2_DATA_BITS - 1)) begin
              state_reg <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            par_ok_reg <= ps2_parity_ok(par_acc_reg, ps2data_sync);
            state_reg  <= ST_STOP;
          end
          ST_STOP: begin
            if (!ps2data_sync) begin
              frame_err_reg <= 1'b1;
            end else if ((CHECK_PARITY != 0) && !par_ok_reg) begin
              parity_err_reg <= 1'b1;
            end else begin
              push_reg      <= 1'b1;
              push_data_reg <= shift_reg;
            end
            state_reg <= ST_IDLE;
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // Receive FIFO
  // -------------------------------------------------------------------------
  sync_fifo #(
    .WIDTH (PS2_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_reg),
    .push_data (push_data_reg),
    .pop       (m_ready),
    .head_data (m_data),
    .valid     (m_valid),
    .count     (fifo_count),
    .overflow  (overflow)
  );

  assign parity_err  = parity_err_reg;
  assign frame_err   = frame_err_reg;
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_ps2_rx_fifo
// Bench for ps2_rx_fifo. Instance A checks parity with a 4-entry FIFO;
// instance B ignores parity. Bytes expected at the stream output are queued
// when a frame is driven and compared as the consumer accepts them.
// ---------------------------------------------------------------------------
module tb_ps2_rx_fifo;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 500;
  localparam int DEPTH      = 4;
  localparam int HALF       = 30;   // PS/2 half period in system clocks

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       line_clk = 1'b1;
  logic       line_data = 1'b1;
  logic       line_sel = 1'b0;     // 0 drives instance A, 1 drives B

  logic       a_ps2clk, a_ps2data, b_ps2clk, b_ps2data;
  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid;
  logic       a_ready = 1'b1;
  logic       b_ready = 1'b1;
  logic [2:0] a_count, b_count;
  logic       a_par, a_frm, a_to, a_ovf;
  logic       b_par, b_frm, b_to, b_ovf;

  assign a_ps2clk  = line_sel ? 1'b1 : line_clk;
  assign a_ps2data = line_sel ? 1'b1 : line_data;
  assign b_ps2clk  = line_sel ? line_clk  : 1'b1;
  assign b_ps2data = line_sel ? line_data : 1'b1;

  always #5 clk = ~clk;

  ps2_rx_fifo #(
    .FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT),
    .FIFO_DEPTH(DEPTH), .CHECK_PARITY(1)
  ) dut_a (
    .clk(clk), .reset(reset), .ps2clk(a_ps2clk), .ps2data(a_ps2data),
    .m_data(a_data), .m_valid(a_valid), .m_ready(a_ready),
    .fifo_count(a_count), .parity_err(a_par), .frame_err(a_frm),
    .timeout_err(a_to), .overflow(a_ovf)
  );

  ps2_rx_fifo #(
    .FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT),
    .FIFO_DEPTH(DEPTH), .CHECK_PARITY(0)
  ) dut_b (
    .clk(clk), .reset(reset), .ps2clk(b_ps2clk), .ps2data(b_ps2data),
    .m_data(b_data), .m_valid(b_valid), .m_ready(b_ready),
    .fifo_count(b_count), .parity_err(b_par), .frame_err(b_frm),
    .timeout_err(b_to), .overflow(b_ovf)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Scoreboards and pulse counters
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int a_par_n = 0, a_frm_n = 0, a_to_n = 0, a_ovf_n = 0;
  int b_par_n = 0, b_rx_n = 0, a_rx_n = 0;

  always @(negedge clk) begin
    if (reset) begin
      if (a_par) a_par_n++;
      if (a_frm) a_frm_n++;
      if (a_to)  a_to_n++;
      if (a_ovf) a_ovf_n++;
      if (b_par) b_par_n++;
      if (a_valid && a_ready) begin
        a_rx_n++;
        $display("rx A: byte 0x%02h", a_data);
        if (qa.size() == 0) check("unexpected_byte_a", int'(a_data), -1);
        else check("byte_a", int'(a_data), int'(qa.pop_front()));
      end
      if (b_valid && b_ready) begin
        b_rx_n++;
        $display("rx B: byte 0x%02h", b_data);
        if (qb.size() == 0) check("unexpected_byte_b", int'(b_data), -1);
        else check("byte_b", int'(b_data), int'(qb.pop_front()));
      end
    end
  end

  // Drive the first nbits bits of a frame (start, data LSB first, parity, stop).
  task automatic send_frame(input bit sel, input logic [7:0] d, input bit flip_par,
                            input bit stop_bit, input int nbits);
    logic [10:0] bits;
    bits = {stop_bit, (~^d) ^ flip_par, d, 1'b0};
    line_sel = sel;
    for (int i = 0; i < nbits; i++) begin
      line_data = bits[i];
      repeat (HALF) @(negedge clk);
      line_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      line_clk = 1'b1;
    end
    repeat (HALF) @(negedge clk);
    line_data = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] d;
    bit         flip_par;
    bit         stop_bit;
    int         exp_par;
    int         exp_frm;
    bit         exp_push;
  } vec_t;

  vec_t vecs[6];
  int   s_par, s_frm, s_to, s_ovf, s_rx;

  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 0, 0, 1'b1};
    vecs[1] = '{8'hF0, 1'b0, 1'b1, 0, 0, 1'b1};
    vecs[2] = '{8'h1C, 1'b1, 1'b1, 1, 0, 1'b0};
    vecs[3] = '{8'h5A, 1'b0, 1'b0, 0, 1, 1'b0};
    vecs[4] = '{8'hAA, 1'b0, 1'b1, 0, 0, 1'b1};
    vecs[5] = '{8'h3C, 1'b1, 1'b0, 0, 1, 1'b0};  // stop error beats parity error

    // Reset values
    repeat (4) @(negedge clk);
    check("rst_valid", int'(a_valid), 0);
    check("rst_data",  int'(a_data), 0);
    check("rst_count", int'(a_count), 0);
    check("rst_errs",  int'({a_par, a_frm, a_to, a_ovf}), 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Table of single frames on A
    for (int i = 0; i < 6; i++) begin
      s_par = a_par_n; s_frm = a_frm_n; s_to = a_to_n;
      if (vecs[i].exp_push) qa.push_back(vecs[i].d);
      send_frame(1'b0, vecs[i].d, vecs[i].flip_par, vecs[i].stop_bit, 11);
      check($sformatf("vec%0d_parity_err", i), a_par_n - s_par, vecs[i].exp_par);
      check($sformatf("vec%0d_frame_err", i), a_frm_n - s_frm, vecs[i].exp_frm);
      check($sformatf("vec%0d_timeout", i), a_to_n - s_to, 0);
      check($sformatf("vec%0d_pending", i), qa.size(), 0);
      check($sformatf("vec%0d_count", i), int'(a_count), 0);
    end

    // Parity ignored on B: bad-parity 0x1C is delivered, no pulse
    s_rx = b_rx_n;
    qb.push_back(8'h1C);
    send_frame(1'b1, 8'h1C, 1'b1, 1'b1, 11);
    check("nopar_pulse", b_par_n, 0);
    check("nopar_delivered", b_rx_n - s_rx, 1);
    check("nopar_pending", qb.size(), 0);

    // Glitch: 3-cycle low with data low must not start a frame
    s_rx = a_rx_n; s_to = a_to_n;
    line_sel = 1'b0; line_data = 1'b0; line_clk = 1'b0;
    repeat (3) @(negedge clk);
    line_clk = 1'b1; line_data = 1'b1;
    repeat (TIMEOUT + 100) @(negedge clk);
    check("glitch_timeout", a_to_n - s_to, 0);
    qa.push_back(8'h33);
    send_frame(1'b0, 8'h33, 1'b0, 1'b1, 11);
    check("glitch_next_rx", a_rx_n - s_rx, 1);
    check("glitch_pending", qa.size(), 0);

    // Watchdog: stall after start + 4 data bits
    s_to = a_to_n; s_frm = a_frm_n; s_par = a_par_n;
    send_frame(1'b0, 8'hFF, 1'b0, 1'b1, 5);
    repeat (TIMEOUT + 100) @(negedge clk);
    check("timeout_pulse", a_to_n - s_to, 1);
    check("timeout_no_other", (a_frm_n - s_frm) + (a_par_n - s_par), 0);
    qa.push_back(8'h12);
    send_frame(1'b0, 8'h12, 1'b0, 1'b1, 11);
    check("timeout_next_pending", qa.size(), 0);

    // Overflow / backpressure
    a_ready = 1'b0;
    s_ovf = a_ovf_n;
    for (int i = 1; i <= 5; i++) begin
      if (i <= DEPTH) qa.push_back(8'(i));
      send_frame(1'b0, 8'(i), 1'b0, 1'b1, 11);
      check($sformatf("fill%0d_count", i), int'(a_count), (i <= DEPTH) ? i : DEPTH);
    end
    check("ovf_pulse", a_ovf_n - s_ovf, 1);
    check("stall_head", int'(a_data), 1);
    check("stall_valid", int'(a_valid), 1);
    s_rx = a_rx_n;
    a_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("drain_rx", a_rx_n - s_rx, DEPTH);
    check("drain_pending", qa.size(), 0);
    check("drain_count", int'(a_count), 0);

    // Reset mid-frame with a byte queued
    a_ready = 1'b0;
    qa.push_back(8'h44);
    send_frame(1'b0, 8'h44, 1'b0, 1'b1, 11);
    check("pre_rst_count", int'(a_count), 1);
    send_frame(1'b0, 8'h00, 1'b0, 1'b1, 6);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", int'(a_valid), 0);
    check("mid_rst_data", int'(a_data), 0);
    check("mid_rst_count", int'(a_count), 0);
    reset = 1'b1;
    qa.delete();
    s_to = a_to_n; s_rx = a_rx_n;
    repeat (TIMEOUT + 100) @(negedge clk);
    check("post_rst_timeout", a_to_n - s_to, 0);
    a_ready = 1'b1;
    qa.push_back(8'h77);
    send_frame(1'b0, 8'h77, 1'b0, 1'b1, 11);
    check("post_rst_rx", a_rx_n - s_rx, 1);
    check("post_rst_pending", qa.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised next-generation PS/2 device-to-host receiver. It accepts 11-bit PS/2 frames on the keyboard/mouse lines and filters glitches on the PS/2 clock. It checks odd parity and the stop bit, and aborts stalled frames with a watchdog. Accepted bytes are buffered in a FIFO and drained through a valid/ready stream. It sits between the board PS/2 pins and the scan-code/command decoder, which may stall without losing bytes.

Parameters:
FILTER_LEN, 8, system clocks the synchronised ps2clk must hold a new level before the filtered clock changes (>=1)
TIMEOUT_CYCLES, 100000, system clocks allowed between PS/2 falling edges inside a frame before abort
FIFO_DEPTH, 16, receive FIFO entries (power of 2, >=2)
CHECK_PARITY, 1, 1 = frames with bad parity are discarded; 0 = parity ignored, parity_err never pulses

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
ps2clk  input  1  raw PS/2 clock pin
ps2data  input  1  raw PS/2 data pin
m_data  output  8  byte at FIFO head
m_valid  output  1  FIFO non-empty
m_ready  input  1  consumer accepts m_data when m_valid & m_ready
fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy
parity_err  output  1  1-cycle pulse: parity mismatch, frame discarded
frame_err  output  1  1-cycle pulse: stop bit sampled 0, frame discarded
timeout_err  output  1  1-cycle pulse: watchdog abort
overflow  output  1  1-cycle pulse: good byte dropped because FIFO full

Behaviour:
- Reset (reset=0 at clk edge): all synchronisers and filtered clock = 1; state IDLE; counters 0; FIFO empty. Outputs: m_valid=0, m_data=0, fifo_count=0, all error pulses 0. Reset mid-frame discards the partial frame.
- Input conditioning: ps2clk and ps2data each pass through a 2-flop synchroniser.
- Filter: the filtered clock changes only after the synchronised ps2clk differs from it for FILTER_LEN consecutive cycles. Shorter pulses are ignored.
- Edge: fall = filtered clock 1->0, one cycle wide. Data is sampled from the synchronised ps2data on that cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
- IDLE: on fall with data=0, clear bit count and parity accumulator, go to DATA. A fall with data=1 is ignored.
- DATA: on each fall, shift in LSB-first and XOR into the parity accumulator. After the 8th bit, go to PARITY.
- PARITY: on fall, record parity_ok = (accumulator ^ bit)==1, i.e. odd parity. Always go to STOP, so the stop bit is consumed and the frame does not resynchronise mid-stream.
- STOP: on fall:
  - If data=0: pulse frame_err (takes priority over parity_err), discard.
  - Else if CHECK_PARITY and !parity_ok: pulse parity_err, discard.
  - Else push the byte.
  - In all cases go to IDLE.
- Watchdog: counter cleared on every fall and in IDLE. In DATA/PARITY/STOP, reaching TIMEOUT_CYCLES pulses timeout_err and forces IDLE. A fall on the same cycle wins, so there is no timeout.
- Latency: the push is registered on the cycle after the stop-bit fall, and m_valid is high on the following cycle.
- Pop: on m_valid & m_ready, the head advances and m_data shows the next entry the next cycle. m_data is held stable while m_valid & !m_ready.
- Push/pop interaction:
  - Simultaneous push and pop: count unchanged, both succeed; when full, the push is accepted because the pop frees the slot.
  - Push while full without pop: byte dropped, overflow pulses, contents unchanged.
- Pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.
- m_ready while empty: no effect.

Decomposition:
- Package ps2_pkg holds:
  - FSM state encoding (IDLE/DATA/PARITY/STOP);
  - PS2_DATA_BITS = 8;
  - the odd-parity constant.
- One natural sub-module: sync_fifo (parametrised width/depth, count output, push/pop with full/empty semantics as above). It is reusable for the planned ps2_tx command queue.
- The filter and FSM stay in ps2_rx_fifo.

Test Plan:
- Good frames: send 0x1C (parity 0), then 0xF0 (parity 1), PS/2 period 80 us, m_ready=1 -> m_data 0x1C then 0xF0, each m_valid once; no error pulses.
- Parity: send 0x1C with parity bit 1 -> one parity_err pulse after stop, fifo_count stays 0. Repeat with CHECK_PARITY=0 -> 0x1C delivered, no pulse.
- Framing: send 0x5A with stop bit 0 -> frame_err pulse only, nothing queued. Next good 0xAA is received correctly.
- Glitch/timeout: inject a 3-cycle low on ps2clk (FILTER_LEN=8) -> no state change. Stop after 4 data bits for TIMEOUT_CYCLES -> timeout_err pulse, IDLE. Following 0x12 is received.
- Overflow/backpressure: FIFO_DEPTH=4, m_ready=0, send 0x01..0x05 -> fifo_count=4, overflow pulse on 0x05. Raise m_ready -> 0x01..0x04 in order, count returns to 0.
- Reset: reset=0 for 1 cycle after 5 data bits -> all outputs at reset values, the partial frame is lost, and the next 0x77 is received intact.
